// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction fetch front end with credit-limited in-order fetch FIFO
// Issues sequential word fetches, buffers returned words with their addresses, flushes on jump.
module fetch_buffer #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  state_e        state_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] drop_q, drop_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   addr_mem_q [DEPTH];

  logic [31:0] inflight;
  logic        req, fire, push, pop, drop_rsp, empty;
  logic        unused_jump_lsb;

  assign unused_jump_lsb = ^jump_addr_i[1:0];

  // Credit counts buffered words plus live requests; responses being dropped hold no slot.
  assign empty    = (count_q == '0);
  assign inflight = 32'(count_q) + 32'(out_q) - 32'(drop_q);
  assign req      = rst && !jump_flag_i && (32'(out_q) < 32'(MAX_OUTSTANDING))
                    && (inflight < 32'(DEPTH));
  assign fire     = req && imem_gnt_i;
  assign drop_rsp = imem_rvalid_i && (state_q == ST_FLUSH);
  assign push     = rst && imem_rvalid_i && !drop_rsp && !jump_flag_i;
  assign pop      = !empty && !stall_i && !jump_flag_i;

  always_comb begin
    out_d      = out_q + OW'(fire) - OW'(imem_rvalid_i);
    fetch_pc_d = fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
    rsp_pc_d   = push ? rsp_pc_q + 32'd4 : rsp_pc_q;
    drop_d     = drop_rsp ? drop_q - OW'(1) : drop_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    if (jump_flag_i) begin
      // Every request granted before the jump is still owed a response; drop them all.
      fetch_pc_d = {jump_addr_i[31:2], 2'b00};
      rsp_pc_d   = {jump_addr_i[31:2], 2'b00};
      drop_d     = out_q - OW'(imem_rvalid_i);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= (drop_d != '0) ? ST_FLUSH : ST_RUN;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= imem_rdata_i;
      addr_mem_q[wr_ptr_q] <= rsp_pc_q;
    end
  end

  assign imem_req_o   = req;
  assign imem_addr_o  = fetch_pc_q;
  assign inst_valid_o = rst && !empty;
  assign inst_o       = inst_valid_o ? inst_mem_q[rd_ptr_q] : NOP;
  assign inst_addr_o  = inst_valid_o ? addr_mem_q[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - directed and random bench for fetch_buffer
// Memory model answers granted requests in order after a configurable latency with data addr|0x1000.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        stall_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  int n_checks = 0;
  int n_fail   = 0;

  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          gnt_rand = 1'b0;
  logic [31:0] pq_addr[$];
  int          pq_due[$];
  logic [31:0] exp_addr = '0;

  fetch_buffer #(.DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .stall_i      (stall_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: record handshakes mid-cycle, present responses just after the edge.
  always @(negedge clk) begin : mem_sample
    int due;
    if (!rst) begin
      pq_addr.delete();
      pq_due.delete();
    end else begin
      check_eq("outstanding_le_max", 32'(pq_addr.size() <= 2), 32'd1);
      if (jump_flag_i) check_eq("no_req_on_jump", 32'(imem_req_o), 32'd0);
      if (imem_rvalid_i && pq_addr.size() > 0) begin
        void'(pq_addr.pop_front());
        void'(pq_due.pop_front());
      end
      if (imem_req_o && imem_gnt_i) begin
        due = cyc + int'($urandom_range(lat_max, lat_min));
        if (pq_due.size() > 0 && due <= pq_due[$]) due = pq_due[$] + 1;
        pq_addr.push_back(imem_addr_o);
        pq_due.push_back(due);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    imem_gnt_i = gnt_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    if (pq_due.size() > 0 && pq_due[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = pq_addr[0] | 32'h1000;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
  end

  // Stream reference: consumed words follow the last reset/jump target, 4 bytes apart.
  always @(negedge clk) begin
    if (!rst) exp_addr = 32'h0;
    else if (jump_flag_i) exp_addr = {jump_addr_i[31:2], 2'b00};
    else if (inst_valid_o && !stall_i) begin
      check_eq("stream_addr", inst_addr_o, exp_addr);
      check_eq("stream_inst", inst_o, exp_addr | 32'h1000);
      exp_addr = exp_addr + 32'd4;
    end
  end

  task automatic wait_valid(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (inst_valid_o) return;
      tick();
    end
  endtask

  logic [31:0] t1_req_addr [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
  logic        t1_valid    [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [31:0] t1_head     [5] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8};

  initial begin
    logic [31:0] head;
    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_req", 32'(imem_req_o), 32'd0);
    check_eq("rst_valid", 32'(inst_valid_o), 32'd0);
    check_eq("rst_inst", inst_o, 32'h13);
    check_eq("rst_addr", inst_addr_o, 32'h0);
    tick();
    rst = 1'b1;

    // Latency and sequential stream after reset release
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("t1_req", 32'(imem_req_o), 32'd1);
      check_eq("t1_req_addr", imem_addr_o, t1_req_addr[c]);
      check_eq("t1_valid", 32'(inst_valid_o), 32'(t1_valid[c]));
      if (t1_valid[c]) begin
        check_eq("t1_head_addr", inst_addr_o, t1_head[c]);
        check_eq("t1_head_inst", inst_o, t1_head[c] | 32'h1000);
      end
      tick();
    end

    // Stall fills the FIFO, then the fetch stops with nothing outstanding
    stall_i = 1'b1;
    @(negedge clk);
    head = inst_addr_o;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      check_eq("t2_head_held", inst_addr_o, head);
      if (i >= 2) check_eq("t2_req_off", 32'(imem_req_o), 32'd0);
      if (i >= 3) check_eq("t2_outstanding_zero", 32'(pq_addr.size()), 32'd0);
      tick();
    end
    stall_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("t2_gap_free", 32'(inst_valid_o), 32'd1);
      tick();
    end

    // Jump with two requests outstanding, 2-cycle latency
    lat_min = 2;
    lat_max = 2;
    repeat (6) tick();
    for (int n = 0; n < 20 && pq_addr.size() != 2; n++) tick();
    check_eq("t3_two_outstanding", 32'(pq_addr.size()), 32'd2);
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h103;
    @(negedge clk);
    check_eq("t3_req_forced_low", 32'(imem_req_o), 32'd0);
    tick();
    jump_flag_i = 1'b0;
    @(negedge clk);
    check_eq("t3_fifo_empty", 32'(inst_valid_o), 32'd0);
    tick();
    wait_valid(20);
    check_eq("t3_first_valid", 32'(inst_valid_o), 32'd1);
    check_eq("t3_first_addr", inst_addr_o, 32'h100);
    check_eq("t3_first_inst", inst_o, 32'h1100);
    tick();

    // Jump coinciding with rvalid, then a second jump one cycle later
    lat_min = 1;
    lat_max = 1;
    repeat (6) tick();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h180;
    @(negedge clk);
    check_eq("t4_rvalid_in_jump", 32'(imem_rvalid_i), 32'd1);
    tick();
    jump_addr_i = 32'h200;
    @(negedge clk);
    check_eq("t4_empty_after_jump", 32'(inst_valid_o), 32'd0);
    tick();
    jump_flag_i = 1'b0;
    wait_valid(20);
    check_eq("t4_first_valid", 32'(inst_valid_o), 32'd1);
    check_eq("t4_first_addr", inst_addr_o, 32'h200);
    check_eq("t4_first_inst", inst_o, 32'h1200);
    tick();

    // Random grant, latency, stall and jumps
    gnt_rand = 1'b1;
    lat_max  = 3;
    for (int i = 0; i < 5000; i++) begin
      stall_i     = ($urandom_range(99, 0) < 30);
      jump_flag_i = ($urandom_range(99, 0) < 2);
      jump_addr_i = $urandom;
      tick();
    end
    stall_i     = 1'b0;
    jump_flag_i = 1'b0;
    gnt_rand    = 1'b0;
    lat_max     = 1;
    repeat (8) tick();

    // Reset mid-stream with two entries buffered
    stall_i = 1'b1;
    tick();
    stall_i = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    check_eq("t6_rst_valid", 32'(inst_valid_o), 32'd0);
    check_eq("t6_rst_req", 32'(imem_req_o), 32'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_after_valid", 32'(inst_valid_o), 32'd0);
    check_eq("t6_after_inst", inst_o, 32'h13);
    check_eq("t6_after_addr", inst_addr_o, 32'h0);
    check_eq("t6_restart_req", 32'(imem_req_o), 32'd1);
    check_eq("t6_restart_pc", imem_addr_o, 32'h0);
    repeat (4) tick();

    // Address wrap at the top of the space
    jump_flag_i = 1'b1;
    jump_addr_i = 32'hFFFF_FFF8;
    tick();
    jump_flag_i = 1'b0;
    wait_valid(20);
    check_eq("t7_wrap_a", inst_addr_o, 32'hFFFF_FFF8);
    tick();
    @(negedge clk);
    check_eq("t7_wrap_b", inst_addr_o, 32'hFFFF_FFFC);
    check_eq("t7_wrap_b_inst", inst_o, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    check_eq("t7_wrap_c_valid", 32'(inst_valid_o), 32'd1);
    check_eq("t7_wrap_c", inst_addr_o, 32'h0);
    check_eq("t7_wrap_c_inst", inst_o, 32'h1000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
